acs_scheduler: RTL and testbench

ACS_SCHEDULER -- requirements
Module: acs_scheduler

---
 rtl/acs_scheduler.sv | 148 ++++++++++++++
 tb/tb_acs_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/acs_scheduler.sv
// Sequences one trellis step through a shared ACS unit: one target state per cycle,
// gathers the decision bits into a survivor word and tracks the step minimum for normalization.
module acs_scheduler #(
    parameter int NUM_STATES  = 64,
    parameter int MW          = 7,
    parameter int NORM_THRESH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sym_valid,
    input  logic                          sym_last,
    output logic                          sym_ready,
    output logic                          acs_enable,
    output logic [$clog2(NUM_STATES)-1:0] acs_state,
    input  logic [MW-1:0]                 acs_min_in,
    input  logic                          acs_dec,
    output logic                          norm_en,
    output logic [MW-1:0]                 norm_sub,
    output logic                          surv_valid,
    input  logic                          surv_ready,
    output logic [NUM_STATES-1:0]         surv_word,
    output logic                          surv_last
);

    localparam int            SW       = $clog2(NUM_STATES);
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STATES - 1);
    localparam logic [MW-1:0] THRESH   = MW'(NORM_THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] counter;
    logic [MW-1:0] run_min;
    logic [MW-1:0] min_next;
    logic          dec_pending;
    logic [SW-1:0] dec_idx;
    logic          accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        acs_enable = 1'b0;
        acs_state  = '0;
        surv_valid = 1'b0;
        case (state)
            IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                acs_enable = 1'b1;
                acs_state  = counter;
                if (counter == LAST_IDX) begin
                    state_next = DRAIN;
                end else begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                surv_valid = 1'b1;
                if (surv_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = OUT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = (state == IDLE) && sym_valid;

    // Running minimum including the ACS result arriving this cycle (needed at DRAIN for the final value)
    always_comb begin
        if (acs_min_in < run_min) begin
            min_next = acs_min_in;
        end else begin
            min_next = run_min;
        end
    end

    // Step datapath: counter, delayed ACS index, survivor collection, minimum and normalization
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter     <= '0;
            run_min     <= '1;
            dec_pending <= 1'b0;
            dec_idx     <= '0;
            surv_word   <= '0;
            surv_last   <= 1'b0;
            norm_en     <= 1'b0;
            norm_sub    <= '0;
        end else begin
            // ACS results come back one cycle after the enable, so remember which state they belong to
            dec_pending <= acs_enable;
            dec_idx     <= acs_state;
            if (accept) begin
                counter   <= '0;
                run_min   <= '1;
                surv_word <= '0;
                surv_last <= sym_last;
            end else begin
                if (state == RUN) begin
                    counter <= counter + SW'(1);
                end
                if (dec_pending) begin
                    surv_word[dec_idx] <= acs_dec;
                    run_min            <= min_next;
                end
            end
            if (state == DRAIN) begin
                if (min_next >= THRESH) begin
                    norm_en  <= 1'b1;
                    norm_sub <= min_next;
                end else begin
                    norm_en  <= 1'b0;
                    norm_sub <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Directed bench for acs_scheduler with NUM_STATES=4, MW=7, NORM_THRESH=64; the bench plays the
// role of the ACS unit, answering one cycle after each enable.
module tb_acs_scheduler;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic       sym_last;
    logic       sym_ready;
    logic       acs_enable;
    logic [1:0] acs_state;
    logic [6:0] acs_min_in;
    logic       acs_dec;
    logic       norm_en;
    logic [6:0] norm_sub;
    logic       surv_valid;
    logic       surv_ready;
    logic [3:0] surv_word;
    logic       surv_last;

    int tests;
    int fails;
    logic       cur_en;
    logic [6:0] cur_sub;

    acs_scheduler #(.NUM_STATES(4), .MW(7), .NORM_THRESH(64)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready),
        .acs_enable(acs_enable), .acs_state(acs_state),
        .acs_min_in(acs_min_in), .acs_dec(acs_dec),
        .norm_en(norm_en), .norm_sub(norm_sub),
        .surv_valid(surv_valid), .surv_ready(surv_ready),
        .surv_word(surv_word), .surv_last(surv_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      dec;
        logic [3:0][6:0] mins;
        logic            last;
        int              hold;
        logic [3:0]      word;
        logic            en;
        logic [6:0]      sub;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full step starting in IDLE; checks RUN sequencing, survivor word and normalization outcome.
    task automatic run_step(input vec_t v);
        sym_valid = 1'b1;
        sym_last  = v.last;
        tick();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("acs_enable_run", acs_enable, 1);
            chk("acs_state_run", acs_state, i);
            chk("norm_en_run", norm_en, cur_en);
            chk("norm_sub_run", norm_sub, cur_sub);
            chk("sym_ready_busy", sym_ready, 0);
            sym_valid  = (i == 1);
            surv_ready = (i < 2);
            tick();
            acs_dec    = v.dec[i];
            acs_min_in = v.mins[i];
        end
        sym_valid  = 1'b0;
        surv_ready = 1'b0;
        chk("acs_enable_drain", acs_enable, 0);
        chk("surv_valid_drain", surv_valid, 0);
        tick();
        acs_dec    = 1'b0;
        acs_min_in = 7'd0;
        chk("surv_valid_out", surv_valid, 1);
        chk("surv_word", surv_word, v.word);
        chk("surv_last", surv_last, v.last);
        chk("norm_en_out", norm_en, v.en);
        chk("norm_sub_out", norm_sub, v.sub);
        for (int h = 0; h < v.hold; h++) begin
            sym_valid = 1'b1;
            tick();
            chk("hold_surv_valid", surv_valid, 1);
            chk("hold_surv_word", surv_word, v.word);
            chk("hold_surv_last", surv_last, v.last);
            chk("hold_sym_ready", sym_ready, 0);
        end
        sym_valid  = 1'b0;
        surv_ready = 1'b1;
        tick();
        surv_ready = 1'b0;
        chk("idle_surv_valid", surv_valid, 0);
        chk("idle_sym_ready", sym_ready, 1);
        cur_en  = v.en;
        cur_sub = v.sub;
    endtask

    initial begin
        int accepts;
        int words;
        int last_acc;

        tests = 0;
        fails = 0;
        cur_en  = 1'b0;
        cur_sub = 7'd0;
        rst = 1'b1;
        sym_valid = 1'b0;
        sym_last = 1'b0;
        surv_ready = 1'b0;
        acs_dec = 1'b0;
        acs_min_in = 7'd0;

        vecs[0] = '{4'b1101, {7'd127, 7'd120, 7'd110, 7'd100}, 1'b0, 0,  4'b1101, 1'b1, 7'd100};
        vecs[1] = '{4'b0010, {7'd90,  7'd80,  7'd65,  7'd70},  1'b0, 10, 4'b0010, 1'b1, 7'd65};
        vecs[2] = '{4'b1111, {7'd40,  7'd30,  7'd20,  7'd10},  1'b0, 0,  4'b1111, 1'b0, 7'd0};
        vecs[3] = '{4'b0000, {7'd64,  7'd100, 7'd127, 7'd64},  1'b0, 2,  4'b0000, 1'b1, 7'd64};
        vecs[4] = '{4'b1001, {7'd127, 7'd70,  7'd63,  7'd90},  1'b0, 0,  4'b1001, 1'b0, 7'd0};
        vecs[5] = '{4'b0110, {7'd127, 7'd127, 7'd127, 7'd127}, 1'b1, 0,  4'b0110, 1'b1, 7'd127};
        vecs[6] = '{4'b0101, {7'd5,   7'd80,  7'd90,  7'd100}, 1'b0, 0,  4'b0101, 1'b0, 7'd0};
        vecs[7] = '{4'b0100, {7'd80,  7'd70,  7'd60,  7'd50},  1'b0, 0,  4'b0100, 1'b0, 7'd0};

        tick();
        tick();
        chk("rst_sym_ready", sym_ready, 1);
        chk("rst_acs_enable", acs_enable, 0);
        chk("rst_acs_state", acs_state, 0);
        chk("rst_surv_valid", surv_valid, 0);
        chk("rst_surv_word", surv_word, 0);
        chk("rst_surv_last", surv_last, 0);
        chk("rst_norm_en", norm_en, 0);
        chk("rst_norm_sub", norm_sub, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_sym_ready", sym_ready, 1);

        for (int n = 0; n < 7; n++) begin
            run_step(vecs[n]);
        end

        // Back-to-back steps with constant valid/ready; third step carries sym_last
        sym_valid  = 1'b1;
        surv_ready = 1'b1;
        acs_dec    = 1'b1;
        acs_min_in = 7'd5;
        accepts  = 0;
        words    = 0;
        last_acc = 0;
        for (int t = 0; t < 60 && words < 3; t++) begin
            if (sym_ready && sym_valid) begin
                if (accepts > 0) chk("b2b_period", t - last_acc, 7);
                sym_last = (accepts == 2);
                last_acc = t;
                accepts++;
            end else begin
                sym_last = 1'b0;
            end
            if (surv_valid) begin
                chk("b2b_surv_last", surv_last, (words == 2));
                chk("b2b_surv_word", surv_word, 4'b1111);
                words++;
            end
            tick();
        end
        sym_valid  = 1'b0;
        sym_last   = 1'b0;
        surv_ready = 1'b0;
        acs_dec    = 1'b0;
        acs_min_in = 7'd0;
        chk("b2b_words", words, 3);
        chk("b2b_idle", sym_ready, 1);
        cur_en  = 1'b0;
        cur_sub = 7'd0;

        // Establish nonzero normalization, then reset in the middle of a step
        run_step(vecs[5]);
        sym_valid = 1'b1;
        sym_last  = 1'b1;
        tick();
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        tick();
        acs_dec = 1'b1;
        tick();
        acs_dec = 1'b1;
        chk("pre_rst_acs_state", acs_state, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_acs_enable", acs_enable, 0);
        chk("mid_rst_acs_state", acs_state, 0);
        chk("mid_rst_surv_valid", surv_valid, 0);
        chk("mid_rst_surv_word", surv_word, 0);
        chk("mid_rst_surv_last", surv_last, 0);
        chk("mid_rst_norm_en", norm_en, 0);
        chk("mid_rst_norm_sub", norm_sub, 0);
        tick();
        rst = 1'b0;
        acs_dec = 1'b0;
        tick();
        chk("after_rst_sym_ready", sym_ready, 1);
        chk("after_rst_acs_enable", acs_enable, 0);
        cur_en  = 1'b0;
        cur_sub = 7'd0;
        run_step(vecs[7]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
